// File: rtl/mips_dmem_responder.sv
// Handshaked data-memory responder for the MIPS load/store unit: one word request,
// a fixed Latency-cycle wait, then a held response with read data and error status.
module mips_dmem_responder #(
  parameter int MemSize = 4096,
  parameter int Latency = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [3:0]  ReqByteEn,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespRData,
  output logic        RespError
);

  localparam int Words = MemSize / 4;
  localparam int AW    = (Words > 1) ? $clog2(Words) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [Words];

  logic          w_accept, w_exit, w_done, w_err;
  logic [AW-1:0] w_idx;

  assign ReqReady  = (r_state == ST_IDLE);
  assign RespValid = (r_state == ST_RESP);
  assign RespRData = r_rdata;
  assign RespError = r_err;

  assign w_accept = ReqValid && (r_state == ST_IDLE);
  assign w_exit   = (r_state == ST_WAIT) && (r_cnt == 4'd1);
  assign w_done   = RespValid && RespReady;
  assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr >= 32'(MemSize));
  assign w_idx    = r_addr[AW+1:2];

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (ReqValid) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: if (RespReady) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset)                   r_cnt <= 4'd0;
    else if (w_accept)           r_cnt <= 4'(Latency);
    else if (r_state == ST_WAIT) r_cnt <= r_cnt - 4'd1;
  end

  // Request fields only matter once accepted, so they need no reset.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_write <= ReqWrite;
      r_addr  <= ReqAddr;
      r_wdata <= ReqWData;
      r_be    <= ReqByteEn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_exit) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
    end else if (w_done) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  // Array survives reset; a reset landing on the exit edge cancels the store.
  always_ff @(posedge Clk) begin
    if (!Reset && w_exit && r_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomised bench for mips_dmem_responder: a transaction/cycle-count model predicts
// every output each cycle, with directed literal checks for the key scenarios.
module tb_mips_dmem_responder;
  localparam int LAT = 2;
  localparam int MSZ = 4096;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        ReqValid = 1'b0, ReqWrite = 1'b0, RespReady = 1'b0;
  logic [31:0] ReqAddr = '0, ReqWData = '0;
  logic [3:0]  ReqByteEn = '0;
  logic        ReqReady, RespValid, RespError;
  logic [31:0] RespRData;

  always #5 Clk = ~Clk;

  mips_dmem_responder #(.MemSize(MSZ), .Latency(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqByteEn(ReqByteEn),
    .RespValid(RespValid), .RespReady(RespReady), .RespRData(RespRData), .RespError(RespError)
  );

  int checks = 0, errors = 0;

  // Model: a transaction accepted at edge number A resolves at edge A+LAT and is
  // consumed at the first later edge with RespReady high.
  int          cyc = 0, m_acc = 0;
  bit          live = 0, m_busy = 0;
  logic        m_w, m_er;
  logic [31:0] m_a, m_d, m_rd;
  logic [3:0]  m_be;
  logic [31:0] m_mem [1024];

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      live   = 1;
      m_busy = 0;
    end else if (!m_busy) begin
      if (ReqValid) begin
        m_busy = 1; m_acc = cyc;
        m_w = ReqWrite; m_a = ReqAddr; m_d = ReqWData; m_be = ReqByteEn;
      end
    end else if (cyc == m_acc + LAT) begin
      m_er = (m_a[1:0] != 2'b00) || (m_a >= 32'(MSZ));
      m_rd = 32'd0;
      if (!m_er) begin
        if (m_w) begin
          for (int i = 0; i < 4; i++)
            if (m_be[i]) m_mem[m_a[11:2]][8*i +: 8] = m_d[8*i +: 8];
        end else begin
          m_rd = m_mem[m_a[11:2]];
        end
      end
    end else if (cyc > m_acc + LAT && RespReady) begin
      m_busy = 0;
    end
  end

  always @(negedge Clk) begin
    logic        ev, exp_er;
    logic [31:0] exp_rd;
    if (live) begin
      ev     = m_busy && (cyc >= m_acc + LAT);
      exp_rd = ev ? m_rd : 32'd0;
      exp_er = ev ? m_er : 1'b0;
      checks++;
      if ({ReqReady, RespValid, RespError, RespRData} !== {!m_busy, ev, exp_er, exp_rd}) begin
        errors++;
        $display("FAIL cycle %0d outputs: got rdy=%b vld=%b err=%b rd=%h, want rdy=%b vld=%b err=%b rd=%h",
                 cyc, ReqReady, RespValid, RespError, RespRData, !m_busy, ev, exp_er, exp_rd);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit keep, output int acc);
    int n = 0;
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqWData = d; ReqByteEn = be;
    while (!ReqReady && n < 50) begin @(negedge Clk); n++; end
    if (!ReqReady) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no ReqReady within %0d cycles, want accept", n);
      ReqValid = 1'b0; acc = -1;
      return;
    end
    @(posedge Clk); #1;
    acc = cyc;
    if (!keep) begin
      // Post-accept garbage must be ignored by the responder.
      ReqValid = 1'b0; ReqWrite = 1'($urandom); ReqAddr = $urandom;
      ReqWData = $urandom; ReqByteEn = 4'($urandom);
    end
  endtask

  task automatic get(input int stall, output logic [31:0] rd, output logic er, output int vcyc);
    int n = 0;
    @(negedge Clk);
    while (!RespValid && n < 50) begin @(negedge Clk); n++; end
    if (!RespValid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no RespValid within %0d cycles, want response", n);
      rd = '0; er = 1'b0; vcyc = -1;
      return;
    end
    vcyc = cyc;
    if (stall > 0) begin
      RespReady = 1'b0;
      repeat (stall) @(negedge Clk);
    end
    rd = RespRData; er = RespError;
    RespReady = 1'b1;
    @(posedge Clk); #1;
    RespReady = 1'($urandom_range(0, 1));
  endtask

  logic [31:0] init_v [64];
  logic [31:0] rd, a;
  logic        er;
  int          acc, vc, r;
  int          acc_cyc [4];

  initial begin
    RespReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset_ready", 32'(ReqReady), 32'd1);
    chk("reset_valid", 32'(RespValid), 32'd0);
    chk("reset_rdata", RespRData, 32'd0);
    chk("reset_error", 32'(RespError), 32'd0);

    for (int i = 0; i < 64; i++) begin
      init_v[i] = (i == 8) ? 32'hCAFEF00D : $urandom;
      send(1'b1, 32'(i * 4), init_v[i], 4'hF, 1'b0, acc);
      get(0, rd, er, vc);
    end

    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, acc);
    get(0, rd, er, vc);
    chk("store_err", 32'(er), 32'd0);
    chk("store_rdata", rd, 32'd0);
    send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, acc);
    get(0, rd, er, vc);
    chk("load_full", rd, 32'hDEADBEEF);
    chk("load_full_err", 32'(er), 32'd0);
    chk("load_latency", 32'(vc - acc), 32'(LAT));
    chk("model_pin_full", m_rd, 32'hDEADBEEF);

    send(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, acc);
    get(0, rd, er, vc);
    send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, acc);
    get(0, rd, er, vc);
    chk("load_lane1", rd, 32'hDEADAAEF);
    chk("model_pin_lane1", m_rd, 32'hDEADAAEF);

    send(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 1'b0, acc);
    get(1, rd, er, vc);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    send(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, acc);
    get(0, rd, er, vc);
    chk("range_err", 32'(er), 32'd1);
    chk("range_rdata", rd, 32'd0);
    send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, acc);
    get(0, rd, er, vc);
    chk("after_err_load", rd, 32'hDEADAAEF);

    // A second request waits through a stalled response.
    send(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, acc);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h14; ReqByteEn = 4'h0;
    get(5, rd, er, vc);
    chk("stall_rdata", rd, 32'hDEADAAEF);
    @(negedge Clk);
    chk("ready_after_hs", 32'(ReqReady), 32'd1);
    @(posedge Clk); #1 ReqValid = 1'b0;
    @(negedge Clk);
    chk("accepted_after_hs", 32'(ReqReady), 32'd0);
    get(0, rd, er, vc);
    chk("pending_load", rd, init_v[5]);

    send(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, acc);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_wait_ready", 32'(ReqReady), 32'd1);
    chk("rst_wait_valid", 32'(RespValid), 32'd0);
    send(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, acc);
    get(0, rd, er, vc);
    chk("store_cancelled", rd, 32'hCAFEF00D);

    RespReady = 1'b1;
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h10;
    begin
      int k = 0, n = 0;
      while (k < 4 && n < 60) begin
        if (ReqReady && ReqValid) begin acc_cyc[k] = cyc + 1; k++; end
        if (k < 4) begin @(negedge Clk); n++; end
      end
      @(posedge Clk); #1 ReqValid = 1'b0;
      if (k < 4) begin
        checks++; errors++;
        $display("FAIL b2b_timeout: got %0d accepts, want 4", k);
      end else begin
        for (int j = 1; j < 4; j++)
          chk("b2b_spacing", 32'(acc_cyc[j] - acc_cyc[j-1]), 32'(LAT + 2));
      end
    end
    get(0, rd, er, vc);

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r < 8) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else            a = $urandom | 32'h1000;
      RespReady = 1'($urandom_range(0, 1));
      send(1'($urandom), a, $urandom, 4'($urandom), 1'b0, acc);
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 4)) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
      end else begin
        get($urandom_range(0, 3), rd, er, vc);
      end
    end

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
